// File: rtl/mod_add.sv
// mod_add: two-stage pipelined (a + b) mod q for lazily reduced operands in [0, 2q).
// Each operand set carries its own modulus through the pipeline.
module mod_add (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [23:0] a_i,
   input  logic [23:0] b_i,
   input  logic [22:0] q_i,
   output logic        valid_o,
   output logic [22:0] c_o
);
   logic [24:0] s, q2, s1_d, s1, q1x;
   logic [22:0] q1, c_d;
   logic        v1;
   assign s    = {1'b0, a_i} + {1'b0, b_i};
   assign q2   = {1'b0, q_i, 1'b0};
   assign s1_d = (s >= q2) ? s - q2 : s;
   assign q1x  = {2'b00, q1};
   // Low 23 bits of (s1 - q) equal s1[22:0] - q1 modulo 2^23.
   assign c_d  = (q1 == '0) ? '0 : (s1 >= q1x) ? s1[22:0] - q1 : s1[22:0];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1      <= 1'b0;
         s1      <= '0;
         q1      <= '0;
         valid_o <= 1'b0;
         c_o     <= '0;
      end else begin
         v1      <= valid_i;
         valid_o <= v1;
         if (valid_i) begin
            s1 <= s1_d;
            q1 <= q_i;
         end
         if (v1) c_o <= c_d;
      end
   end
endmodule

// File: tb/tb_mod_add.sv
// tb_mod_add: directed vectors with a scoreboard queue; a negedge monitor
// checks every result's value and arrival cycle, plus hold and reset behaviour.
module tb_mod_add;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic [23:0] a_i = '0;
   logic [23:0] b_i = '0;
   logic [22:0] q_i = '0;
   logic        valid_o;
   logic [22:0] c_o;

   typedef struct {
      logic [22:0] c;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [22:0] last_c = '0;

   mod_add dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
      .a_i(a_i), .b_i(b_i), .q_i(q_i),
      .valid_o(valid_o), .c_o(c_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Inputs change 1 time unit after an edge; the following edge samples them,
   // and the result is due two edges after presentation.
   task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [22:0] q,
                       input logic [22:0] e);
      @(posedge clk_i);
      #1;
      valid_i = 1'b1;
      a_i = a;
      b_i = b;
      q_i = q;
      sb.push_back('{c: e, due: cyc + 2});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         valid_i = 1'b0;
         a_i = 24'hABCDEF;
         b_i = 24'h123456;
         q_i = 23'h7;
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (valid_o) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
               check("result", 32'(c_o), 32'(sb[0].c));
               check("latency", 32'(cyc), 32'(sb[0].due));
               void'(sb.pop_front());
            end
            last_c = c_o;
         end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               check("missing_valid", 32'(valid_o), 32'd1);
               void'(sb.pop_front());
            end
            check("hold", 32'(c_o), 32'(last_c));
         end
      end
   end

   initial begin
      #2;
      check("reset_valid", 32'(valid_o), 32'd0);
      check("reset_c", 32'(c_o), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(2);
      send(20, 3, 40, 23);
      idle(3);
      send(20, 21, 40, 1);
      send(20, 20, 40, 0);
      send(40, 40, 40, 0);
      send(0, 0, 40, 0);
      send(79, 79, 40, 38);
      send(16777213, 16777213, 8388607, 8388605);
      send(5, 3, 0, 0);
      idle(3);
      send(20, 3, 40, 23);
      send(5, 6, 7, 4);
      send(100, 1, 101, 0);
      idle(4);
      send(30, 25, 40, 15);
      send(1, 2, 40, 3);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      check("pre_reset_valid", 32'(valid_o), 32'd1);
      check("pre_reset_c", 32'(c_o), 32'd15);
      #1;
      rst_i = 1'b1;
      sb.delete();
      #1;
      check("async_reset_valid", 32'(valid_o), 32'd0);
      check("async_reset_c", 32'(c_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      last_c = '0;
      idle(4);
      send(20, 3, 40, 23);
      idle(4);
      check("drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
